// File: rtl/line_buffer_win_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cam_lb_pkg
//  Description : Shared types and constants for the 3x3 line-buffer window
//                controller (FSM states, window latency, default geometry).
//  Revision    : 1.0 - initial release
// ============================================================================
package cam_lb_pkg;

    // Default geometry for a 1280x720 8-bit luma stream
    localparam int DW_DEF    = 8;
    localparam int IMG_W_DEF = 1280;
    localparam int IMG_H_DEF = 720;

    // Cycles from pixel acceptance to the registered window output
    localparam int WIN_LAT   = 3;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LINE = 2'd1,
        LINE      = 2'd2
    } lb_state_t;

endpackage
`default_nettype wire

// File: rtl/line_buffer_win_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : line_buffer_win_ctrl_if
//  Description : Camera pixel stream in, two line-RAM ports, 3x3 window out.
//                slave  = controller side, master = environment side
//                (camera source, line RAMs, downstream filter).
//  Revision    : 1.0 - initial release
// ============================================================================
interface line_buffer_win_ctrl_if
    import cam_lb_pkg::*;
#(
    parameter int DW = DW_DEF
);
    // camera stream
    logic          per_frame_vsync;
    logic          per_frame_href;
    logic          per_frame_clken;
    logic [DW-1:0] per_img_y;
    // line RAM ports
    logic          lb0_clken;
    logic [DW-1:0] lb0_din;
    logic [DW-1:0] lb0_dout;
    logic          lb1_clken;
    logic [DW-1:0] lb1_din;
    logic [DW-1:0] lb1_dout;
    // window output
    logic [DW-1:0] matrix_p11, matrix_p12, matrix_p13;
    logic [DW-1:0] matrix_p21, matrix_p22, matrix_p23;
    logic [DW-1:0] matrix_p31, matrix_p32, matrix_p33;
    logic          matrix_valid;
    logic          matrix_vsync;
    logic          matrix_href;
    logic          lb_err;

    modport slave (
        input  per_frame_vsync, per_frame_href, per_frame_clken, per_img_y,
        input  lb0_dout, lb1_dout,
        output lb0_clken, lb0_din, lb1_clken, lb1_din,
        output matrix_p11, matrix_p12, matrix_p13,
        output matrix_p21, matrix_p22, matrix_p23,
        output matrix_p31, matrix_p32, matrix_p33,
        output matrix_valid, matrix_vsync, matrix_href, lb_err
    );

    modport master (
        output per_frame_vsync, per_frame_href, per_frame_clken, per_img_y,
        output lb0_dout, lb1_dout,
        input  lb0_clken, lb0_din, lb1_clken, lb1_din,
        input  matrix_p11, matrix_p12, matrix_p13,
        input  matrix_p21, matrix_p22, matrix_p23,
        input  matrix_p31, matrix_p32, matrix_p33,
        input  matrix_valid, matrix_vsync, matrix_href, lb_err
    );

endinterface
`default_nettype wire

// File: rtl/line_buffer_win_ctrl_shift.sv
`default_nettype none
// ============================================================================
//  Module      : lb_win_shift
//  Description : Aligns the three row taps of an accepted pixel, shifts them
//                into a 3x3 column register window and delays valid/syncs so
//                everything leaves WIN_LAT cycles after acceptance.
//  Revision    : 1.0 - initial release
// ============================================================================
module lb_win_shift
    import cam_lb_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] i_pix,      // current row pixel, cycle t
    input  logic          i_accept,   // pixel accepted, cycle t
    input  logic          i_win_ok,   // pixel is row>=2 and col>=2
    input  logic [DW-1:0] i_tap1,     // RAM0 read data, valid at t+1
    input  logic [DW-1:0] i_tap0,     // RAM1 read data, valid at t+2
    input  logic          i_vsync,
    input  logic          i_href,
    output logic [DW-1:0] o_p11, o_p12, o_p13,
    output logic [DW-1:0] o_p21, o_p22, o_p23,
    output logic [DW-1:0] o_p31, o_p32, o_p33,
    output logic          o_valid,
    output logic          o_vsync,
    output logic          o_href
);

    logic [DW-1:0]      r_pix_d1, r_pix_d2, r_tap1_d1;
    logic               r_acc_d1, r_acc_d2;
    logic               r_ok_d1, r_ok_d2;
    logic [WIN_LAT-1:0] r_vs_pipe, r_hs_pipe;
    logic [DW-1:0]      r_p11, r_p12, r_p13;
    logic [DW-1:0]      r_p21, r_p22, r_p23;
    logic [DW-1:0]      r_p31, r_p32, r_p33;
    logic               r_valid;

    // Bring current row, RAM0 tap and RAM1 tap of one pixel together at t+2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix_d1  <= '0;
            r_pix_d2  <= '0;
            r_tap1_d1 <= '0;
            r_acc_d1  <= 1'b0;
            r_acc_d2  <= 1'b0;
            r_ok_d1   <= 1'b0;
            r_ok_d2   <= 1'b0;
        end else begin
            r_pix_d1  <= i_pix;
            r_pix_d2  <= r_pix_d1;
            r_tap1_d1 <= i_tap1;
            r_acc_d1  <= i_accept;
            r_acc_d2  <= r_acc_d1;
            r_ok_d1   <= i_accept & i_win_ok;
            r_ok_d2   <= r_ok_d1;
        end
    end

    // Shift the window left by one column for each accepted pixel only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p11   <= '0; r_p12 <= '0; r_p13 <= '0;
            r_p21   <= '0; r_p22 <= '0; r_p23 <= '0;
            r_p31   <= '0; r_p32 <= '0; r_p33 <= '0;
            r_valid <= 1'b0;
        end else begin
            if (r_acc_d2) begin
                r_p11 <= r_p12; r_p12 <= r_p13; r_p13 <= i_tap0;
                r_p21 <= r_p22; r_p22 <= r_p23; r_p23 <= r_tap1_d1;
                r_p31 <= r_p32; r_p32 <= r_p33; r_p33 <= r_pix_d2;
            end
            r_valid <= r_ok_d2;
        end
    end

    // Delay frame/line syncs to match the window latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vs_pipe <= '0;
            r_hs_pipe <= '0;
        end else begin
            r_vs_pipe <= {r_vs_pipe[WIN_LAT-2:0], i_vsync};
            r_hs_pipe <= {r_hs_pipe[WIN_LAT-2:0], i_href};
        end
    end

    assign o_p11   = r_p11;
    assign o_p12   = r_p12;
    assign o_p13   = r_p13;
    assign o_p21   = r_p21;
    assign o_p22   = r_p22;
    assign o_p23   = r_p23;
    assign o_p31   = r_p31;
    assign o_p32   = r_p32;
    assign o_p33   = r_p33;
    assign o_valid = r_valid;
    assign o_vsync = r_vs_pipe[WIN_LAT-1];
    assign o_href  = r_hs_pipe[WIN_LAT-1];

endmodule
`default_nettype wire

// File: rtl/line_buffer_win_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : line_buffer_win_ctrl
//  Description : Sequencer for two cascaded line shift RAMs producing a
//                registered 3x3 window (valid-only, no border padding).
//                Optional macro LB_CTRL_ERR_EN enables the sticky lb_err
//                format checker; otherwise lb_err is tied low.
//                Pixels are accepted only once the FSM is in LINE, i.e. from
//                the cycle after the href rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_buffer_win_ctrl
    import cam_lb_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int CW    = 11,
    parameter int RW    = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    line_buffer_win_ctrl_if.slave  bus
);

    localparam logic [CW-1:0] c_col_end = CW'(IMG_W);
    localparam logic [RW-1:0] c_row_end = RW'(IMG_H);

    lb_state_t     r_state, w_state_nxt;
    logic [CW-1:0] r_col, w_col_nxt;
    logic [RW-1:0] r_row, w_row_nxt;
    logic          r_vsync_d, r_href_d;
    logic          r_lb1_clken;

    logic w_vsync_rise, w_href_rise, w_href_fall;
    logic w_pix_strobe, w_col_ok, w_row_ok, w_accept, w_win_ok;

    assign w_vsync_rise = bus.per_frame_vsync & ~r_vsync_d;
    assign w_href_rise  = bus.per_frame_href  & ~r_href_d;
    assign w_href_fall  = ~bus.per_frame_href &  r_href_d;
    assign w_pix_strobe = (r_state == LINE) & bus.per_frame_href & bus.per_frame_clken;
    assign w_col_ok     = (r_col < c_col_end);
    assign w_row_ok     = (r_row < c_row_end);
    assign w_accept     = w_pix_strobe & w_col_ok & w_row_ok;
    assign w_win_ok     = (r_row >= RW'(2)) & (r_col >= CW'(2));

    // Remember previous sync levels for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vsync_d <= 1'b0;
            r_href_d  <= 1'b0;
        end else begin
            r_vsync_d <= bus.per_frame_vsync;
            r_href_d  <= bus.per_frame_href;
        end
    end

    // FSM state and position counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_col   <= '0;
            r_row   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
        end
    end

    // Next state: vsync rise restarts the frame from anywhere; row saturates
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        if (w_vsync_rise) begin
            w_state_nxt = WAIT_LINE;
            w_col_nxt   = '0;
            w_row_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = IDLE;
                end
                WAIT_LINE: begin
                    if (w_href_rise) begin
                        w_state_nxt = LINE;
                    end
                end
                LINE: begin
                    if (w_href_fall) begin
                        w_state_nxt = WAIT_LINE;
                        w_col_nxt   = '0;
                        if (r_row != c_row_end) begin
                            w_row_nxt = r_row + RW'(1);
                        end
                    end else if (w_accept) begin
                        w_col_nxt = r_col + CW'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // RAM1 is written one cycle after RAM0, with RAM0's registered read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lb1_clken <= 1'b0;
        end else begin
            r_lb1_clken <= w_accept;
        end
    end

    // Data buses are zeroed outside their enable so nothing leaks after reset
    assign bus.lb0_clken = w_accept;
    assign bus.lb0_din   = w_accept ? bus.per_img_y : '0;
    assign bus.lb1_clken = r_lb1_clken;
    assign bus.lb1_din   = r_lb1_clken ? bus.lb0_dout : '0;

`ifdef LB_CTRL_ERR_EN
    logic r_err;
    logic w_err_line, w_err_pix, w_err_row, w_err_vs;

    assign w_err_line = (r_state == LINE) & w_href_fall & (r_col != c_col_end);
    assign w_err_pix  = w_pix_strobe & ~w_col_ok;
    assign w_err_row  = (r_state == WAIT_LINE) & w_href_rise & ~w_row_ok;
    assign w_err_vs   = w_vsync_rise & (r_row != '0) & (r_row != c_row_end);

    // Sticky format error, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_err_line | w_err_pix | w_err_row | w_err_vs) begin
            r_err <= 1'b1;
        end
    end

    assign bus.lb_err = r_err;
`else
    assign bus.lb_err = 1'b0;
`endif

    lb_win_shift #(
        .DW(DW)
    ) u_win (
        .clk      (clk),
        .rst      (rst),
        .i_pix    (bus.per_img_y),
        .i_accept (w_accept),
        .i_win_ok (w_win_ok),
        .i_tap1   (bus.lb0_dout),
        .i_tap0   (bus.lb1_dout),
        .i_vsync  (bus.per_frame_vsync),
        .i_href   (bus.per_frame_href),
        .o_p11    (bus.matrix_p11),
        .o_p12    (bus.matrix_p12),
        .o_p13    (bus.matrix_p13),
        .o_p21    (bus.matrix_p21),
        .o_p22    (bus.matrix_p22),
        .o_p23    (bus.matrix_p23),
        .o_p31    (bus.matrix_p31),
        .o_p32    (bus.matrix_p32),
        .o_p33    (bus.matrix_p33),
        .o_valid  (bus.matrix_valid),
        .o_vsync  (bus.matrix_vsync),
        .o_href   (bus.matrix_href)
    );

endmodule
`default_nettype wire

// File: tb/tb_line_buffer_win_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_line_buffer_win_ctrl
//  Description : Directed bench for line_buffer_win_ctrl at 8x6 with
//                behavioural shift RAMs (depth IMG_W, 1-cycle read).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_line_buffer_win_ctrl;
    import cam_lb_pkg::*;

    localparam int DW = 8;
    localparam int W  = 8;
    localparam int H  = 6;
`ifdef LB_CTRL_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    line_buffer_win_ctrl_if #(.DW(DW)) bus();

    line_buffer_win_ctrl #(
        .DW(DW), .IMG_W(W), .IMG_H(H), .CW(4), .RW(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural line shift RAMs
    logic [DW-1:0] ram0 [W] = '{default: '0};
    logic [DW-1:0] ram1 [W] = '{default: '0};
    logic [DW-1:0] ram0_q = '0;
    logic [DW-1:0] ram1_q = '0;
    assign bus.lb0_dout = ram0_q;
    assign bus.lb1_dout = ram1_q;

    always @(posedge clk) begin
        if (bus.lb0_clken) begin
            ram0[0] <= bus.lb0_din;
            for (int i = 1; i < W; i++) ram0[i] <= ram0[i-1];
            ram0_q <= ram0[W-1];
        end
        if (bus.lb1_clken) begin
            ram1[0] <= bus.lb1_din;
            for (int i = 1; i < W; i++) ram1[i] <= ram1[i-1];
            ram1_q <= ram1[W-1];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output collection
    logic [71:0] win_q [$];
    int          vcyc_q [$];
    int          n_lb0 = 0;
    always @(negedge clk) begin
        if (bus.matrix_valid) begin
            win_q.push_back({bus.matrix_p11, bus.matrix_p12, bus.matrix_p13,
                             bus.matrix_p21, bus.matrix_p22, bus.matrix_p23,
                             bus.matrix_p31, bus.matrix_p32, bus.matrix_p33});
            vcyc_q.push_back(cyc);
        end
        if (bus.lb0_clken) n_lb0 <= n_lb0 + 1;
    end

    int checks = 0;
    int errors = 0;
    int t22    = 0;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] exp_win(input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                w[71 - 8*(dr*3+dc) -: 8] = 8'((r - 2 + dr) * 16 + (c - 2 + dc));
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic vs, input logic hs, input logic ce, input logic [7:0] y);
        bus.per_frame_vsync = vs;
        bus.per_frame_href  = hs;
        bus.per_frame_clken = ce;
        bus.per_img_y       = y;
    endtask

    task automatic vsync_start();
        step(); set_in(1'b1, 1'b0, 1'b0, 8'h00);
        step();
        step(); set_in(1'b0, 1'b0, 1'b0, 8'h00);
        step();
    endtask

    // n continuous pixels of one row starting at column c0 (href already high)
    task automatic pixels(input int row, input int c0, input int n, input bit toggle);
        for (int i = c0; i < c0 + n; i++) begin
            step(); set_in(1'b0, 1'b1, 1'b1, 8'(row * 16 + i));
            if (row == 2 && i == 2) t22 = cyc;
            if (toggle) begin
                step(); set_in(1'b0, 1'b1, 1'b0, 8'(row * 16 + i));
            end
        end
    endtask

    task automatic line_tail();
        step(); set_in(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (4) step();
    endtask

    task automatic drive_line(input int row, input int n, input bit toggle);
        step(); set_in(1'b0, 1'b1, 1'b0, 8'h00);   // href leads the first pixel
        pixels(row, 0, n, toggle);
        line_tail();
    endtask

    task automatic check_frame(input string tag, input int base, input int spacing);
        int bad;
        check({tag, " count"}, 72'(win_q.size() - base), 72'(24));
        for (int k = 0; k < 24; k++) begin
            if (base + k < win_q.size())
                check($sformatf("%s win r%0d c%0d", tag, 2 + k / 6, 2 + k % 6),
                      win_q[base + k], exp_win(2 + k / 6, 2 + k % 6));
        end
        if (win_q.size() > base) begin
            check({tag, " first p11/p22/p33"},
                  72'({win_q[base][71:64], win_q[base][39:32], win_q[base][7:0]}),
                  72'(24'h001122));
            check({tag, " latency"}, 72'(vcyc_q[base]), 72'(t22 + WIN_LAT));
        end
        bad = 0;
        for (int k = 1; k < 24; k++) begin
            if (base + k < vcyc_q.size() && (k % 6) != 0 &&
                vcyc_q[base + k] - vcyc_q[base + k - 1] != spacing) bad++;
        end
        check({tag, " valid spacing"}, 72'(bad), 72'(0));
    endtask

    initial begin
        int base;
        int n0;
        set_in(1'b0, 1'b0, 1'b0, 8'h00);

        // Reset state
        repeat (3) step();
        check("reset ctrl", 72'({bus.matrix_valid, bus.lb0_clken, bus.lb1_clken,
                                 bus.matrix_vsync, bus.matrix_href, bus.lb_err}), 72'(0));
        check("reset matrix", {bus.matrix_p11, bus.matrix_p12, bus.matrix_p13,
                               bus.matrix_p21, bus.matrix_p22, bus.matrix_p23,
                               bus.matrix_p31, bus.matrix_p32, bus.matrix_p33}, 72'(0));
        rst = 1'b0;

        // Ramp frame, continuous clken
        base = win_q.size();
        n0   = n_lb0;
        vsync_start();
        for (int r = 0; r < H; r++) drive_line(r, W, 1'b0);
        check("ramp lb0_clken count", 72'(n_lb0 - n0), 72'(W * H));
        check_frame("ramp", base, 1);
        check("ramp lb_err", 72'(bus.lb_err), 72'(0));

        // Same frame, clken 1,0,1,0
        base = win_q.size();
        vsync_start();
        for (int r = 0; r < H; r++) drive_line(r, W, 1'b1);
        check_frame("toggle", base, 2);

        // Over-long line
        vsync_start();
        n0 = n_lb0;
        drive_line(0, 10, 1'b0);
        check("long line lb0_clken count", 72'(n_lb0 - n0), 72'(W));
        check("long line lb_err", 72'(bus.lb_err), 72'(EXP_ERR));
        step(); rst = 1'b1;
        step(); rst = 1'b0;

        // Reset mid-frame at row 3
        vsync_start();
        for (int r = 0; r < 3; r++) drive_line(r, W, 1'b0);
        step(); set_in(1'b0, 1'b1, 1'b0, 8'h00);
        pixels(3, 0, 4, 1'b0);
        step(); set_in(1'b0, 1'b1, 1'b1, 8'h34);
        rst = 1'b1;
        @(negedge clk);
        check("mid rst ctrl", 72'({bus.matrix_valid, bus.lb0_clken, bus.lb1_clken,
                                   bus.lb0_din, bus.lb1_din, bus.matrix_vsync,
                                   bus.matrix_href, bus.lb_err}), 72'(0));
        check("mid rst matrix", {bus.matrix_p11, bus.matrix_p12, bus.matrix_p13,
                                 bus.matrix_p21, bus.matrix_p22, bus.matrix_p23,
                                 bus.matrix_p31, bus.matrix_p32, bus.matrix_p33}, 72'(0));
        base = win_q.size();
        step();
        step(); rst = 1'b0;
        n0 = n_lb0;
        pixels(3, 5, 3, 1'b0);
        line_tail();
        for (int r = 4; r < H; r++) drive_line(r, W, 1'b0);
        check("after rst no valid", 72'(win_q.size() - base), 72'(0));
        check("after rst no clken", 72'(n_lb0 - n0), 72'(0));
        base = win_q.size();
        vsync_start();
        for (int r = 0; r < H; r++) drive_line(r, W, 1'b0);
        check_frame("post rst", base, 1);

        // vsync rise with href high at col 4
        vsync_start();
        base = win_q.size();
        n0   = n_lb0;
        step(); set_in(1'b0, 1'b1, 1'b0, 8'h00);
        pixels(0, 0, 4, 1'b0);
        step(); set_in(1'b1, 1'b1, 1'b0, 8'h00);
        for (int i = 5; i < 8; i++) begin
            step(); set_in(1'b1, 1'b1, 1'b1, 8'(8'h90 + i));
        end
        check("vsync restart clken count", 72'(n_lb0 - n0), 72'(4));
        step(); set_in(1'b1, 1'b0, 1'b0, 8'h00);
        step(); set_in(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (3) step();
        for (int r = 0; r < H; r++) drive_line(r, W, 1'b0);
        check_frame("vsync restart", base, 1);
        check("vsync restart lb_err", 72'(bus.lb_err), 72'(0));

        // Seven lines in a frame
        vsync_start();
        base = win_q.size();
        for (int r = 0; r < H; r++) drive_line(r, W, 1'b0);
        n0 = n_lb0;
        drive_line(H, W, 1'b0);
        check("7th line clken", 72'(n_lb0 - n0), 72'(0));
        check_frame("seven lines", base, 1);
        check("seven lines lb_err", 72'(bus.lb_err), 72'(EXP_ERR));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
